// File: rtl/phy_rx_link_ctrl_if.sv
// phy_rx_link_ctrl_if: lane byte inputs and link status/forwarding outputs of the receive link controller
interface phy_rx_link_ctrl_if;
    logic [7:0] data_par_0;
    logic       valid_par_0;
    logic [7:0] data_par_1;
    logic       valid_par_1;
    logic       lane_sync_0;
    logic       lane_sync_1;
    logic       link_active;
    logic [7:0] data_fwd_0;
    logic       valid_fwd_0;
    logic [7:0] data_fwd_1;
    logic       valid_fwd_1;
    logic       flush;
    logic [7:0] sync_loss_cnt;
    modport slave (
        input  data_par_0, valid_par_0, data_par_1, valid_par_1,
        output lane_sync_0, lane_sync_1, link_active, data_fwd_0, valid_fwd_0,
               data_fwd_1, valid_fwd_1, flush, sync_loss_cnt
    );
    modport master (
        output data_par_0, valid_par_0, data_par_1, valid_par_1,
        input  lane_sync_0, lane_sync_1, link_active, data_fwd_0, valid_fwd_0,
               data_fwd_1, valid_fwd_1, flush, sync_loss_cnt
    );
endinterface

// File: rtl/phy_rx_link_ctrl.sv
// phy_rx_link_ctrl: per-lane symbol sync, link training/active sequencing and payload forwarding for two lanes
module phy_rx_link_ctrl #(
    parameter logic [7:0] COM_CHAR   = 8'hBC,
    parameter logic [7:0] IDLE_CHAR  = 8'h7C,
    parameter int         SYNC_COUNT = 4,
    parameter int         ERR_LIMIT  = 4
) (
    input logic              clk_f,
    input logic              reset,
    phy_rx_link_ctrl_if.slave bus
);
    localparam logic [1:0] DOWN   = 2'd0;
    localparam logic [1:0] TRAIN  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [3:0] SYNC_N = 4'(SYNC_COUNT);
    localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);

    logic [1:0][7:0] data_par;
    logic [1:0]      valid_par;
    logic [1:0]      sync_q, sync_d;
    logic [1:0][3:0] com_cnt_q, com_cnt_d, err_cnt_q, err_cnt_d;
    logic [1:0][3:0] com_inc, err_inc;
    logic [1:0]      got_com, sync_hit, err_hit;
    logic [1:0][7:0] data_fwd_q, data_fwd_d;
    logic [1:0]      valid_fwd_q, valid_fwd_d;
    logic [1:0]      state_q, state_d;
    logic            flush_q, flush_d;
    logic [7:0]      loss_cnt_q, loss_cnt_d;
    logic            both_sync, idle_both;

    assign data_par  = {bus.data_par_1, bus.data_par_0};
    assign valid_par = {bus.valid_par_1, bus.valid_par_0};

    always_comb begin
        both_sync = &sync_q;
        idle_both = (&valid_par) && data_par[0] == IDLE_CHAR && data_par[1] == IDLE_CHAR;
        for (int i = 0; i < 2; i++) begin
            com_inc[i]     = com_cnt_q[i] + 4'd1;
            err_inc[i]     = err_cnt_q[i] + 4'd1;
            got_com[i]     = valid_par[i] && data_par[i] == COM_CHAR;
            sync_hit[i]    = got_com[i] && com_inc[i] == SYNC_N;
            err_hit[i]     = !valid_par[i] && err_inc[i] == ERR_N;
            sync_d[i]      = sync_q[i] ? !err_hit[i] : sync_hit[i];
            com_cnt_d[i]   = (sync_q[i] || sync_hit[i] || (valid_par[i] && !got_com[i])) ? 4'd0 :
                             got_com[i] ? com_inc[i] : com_cnt_q[i];
            err_cnt_d[i]   = (!sync_q[i] || err_hit[i] || valid_par[i]) ? 4'd0 : err_inc[i];
            valid_fwd_d[i] = state_q == ACTIVE && both_sync && valid_par[i] &&
                             data_par[i] != COM_CHAR && data_par[i] != IDLE_CHAR;
        end
        data_fwd_d = data_par;
        // Losing either lane always wins, including over an IDLE seen in TRAIN
        state_d    = !both_sync ? DOWN :
                     state_q == DOWN ? TRAIN :
                     (state_q == TRAIN && idle_both) ? ACTIVE : state_q;
        flush_d    = state_q == ACTIVE && !both_sync;
        loss_cnt_d = (flush_d && loss_cnt_q != 8'hFF) ? loss_cnt_q + 8'd1 : loss_cnt_q;
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            com_cnt_q   <= '0;
            err_cnt_q   <= '0;
            data_fwd_q  <= '0;
            valid_fwd_q <= '0;
            state_q     <= DOWN;
            flush_q     <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            sync_q      <= sync_d;
            com_cnt_q   <= com_cnt_d;
            err_cnt_q   <= err_cnt_d;
            data_fwd_q  <= data_fwd_d;
            valid_fwd_q <= valid_fwd_d;
            state_q     <= state_d;
            flush_q     <= flush_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign bus.lane_sync_0   = sync_q[0];
    assign bus.lane_sync_1   = sync_q[1];
    assign bus.link_active   = state_q == ACTIVE;
    assign bus.data_fwd_0    = data_fwd_q[0];
    assign bus.data_fwd_1    = data_fwd_q[1];
    assign bus.valid_fwd_0   = valid_fwd_q[0];
    assign bus.valid_fwd_1   = valid_fwd_q[1];
    assign bus.flush         = flush_q;
    assign bus.sync_loss_cnt = loss_cnt_q;
endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// tb_phy_rx_link_ctrl: vector table with a scoreboard queue plus sequences for resync, saturation and async reset
module tb_phy_rx_link_ctrl;
    logic clk_f = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   losses = 0;

    phy_rx_link_ctrl_if bus ();
    phy_rx_link_ctrl dut (.clk_f(clk_f), .reset(reset), .bus(bus));

    always #5 clk_f = ~clk_f;

    typedef struct {
        logic        v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic [29:0] exp;
    } vec_t;

    vec_t        tbl[19];
    logic [29:0] sbq[$];

    function automatic logic [29:0] mk(input logic s0, s1, act, f0, f1, fl,
                                       input logic [7:0] cnt, df0, df1);
        return {s0, s1, act, f0, f1, fl, cnt, df0, df1};
    endfunction

    function automatic logic [29:0] obs();
        return {bus.lane_sync_0, bus.lane_sync_1, bus.link_active, bus.valid_fwd_0,
                bus.valid_fwd_1, bus.flush, bus.sync_loss_cnt, bus.data_fwd_0, bus.data_fwd_1};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        bus.valid_par_0 = v0;
        bus.data_par_0  = d0;
        bus.valid_par_1 = v1;
        bus.data_par_1  = d1;
        @(posedge clk_f);
        #1;
    endtask

    initial begin
        logic [29:0] e;
        tbl[0]  = '{1, 8'hBC, 1, 8'hBC, mk(0,0,0,0,0,0, 8'd0, 8'hBC, 8'hBC)};
        tbl[1]  = '{1, 8'hBC, 1, 8'hBC, mk(0,0,0,0,0,0, 8'd0, 8'hBC, 8'hBC)};
        tbl[2]  = '{1, 8'hBC, 1, 8'hBC, mk(0,0,0,0,0,0, 8'd0, 8'hBC, 8'hBC)};
        tbl[3]  = '{1, 8'hBC, 1, 8'hBC, mk(1,1,0,0,0,0, 8'd0, 8'hBC, 8'hBC)};
        tbl[4]  = '{1, 8'h00, 1, 8'h00, mk(1,1,0,0,0,0, 8'd0, 8'h00, 8'h00)};
        tbl[5]  = '{1, 8'h7C, 1, 8'h7C, mk(1,1,1,0,0,0, 8'd0, 8'h7C, 8'h7C)};
        tbl[6]  = '{1, 8'h12, 1, 8'h34, mk(1,1,1,1,1,0, 8'd0, 8'h12, 8'h34)};
        tbl[7]  = '{1, 8'hBC, 1, 8'h7C, mk(1,1,1,0,0,0, 8'd0, 8'hBC, 8'h7C)};
        tbl[8]  = '{1, 8'hAB, 1, 8'hCD, mk(1,1,1,1,1,0, 8'd0, 8'hAB, 8'hCD)};
        tbl[9]  = '{1, 8'hAB, 0, 8'h00, mk(1,1,1,1,0,0, 8'd0, 8'hAB, 8'h00)};
        tbl[10] = '{1, 8'hAB, 0, 8'h00, mk(1,1,1,1,0,0, 8'd0, 8'hAB, 8'h00)};
        tbl[11] = '{1, 8'hAB, 0, 8'h00, mk(1,1,1,1,0,0, 8'd0, 8'hAB, 8'h00)};
        tbl[12] = '{1, 8'hAB, 1, 8'h55, mk(1,1,1,1,1,0, 8'd0, 8'hAB, 8'h55)};
        tbl[13] = '{1, 8'h11, 0, 8'h00, mk(1,1,1,1,0,0, 8'd0, 8'h11, 8'h00)};
        tbl[14] = '{1, 8'h11, 0, 8'h00, mk(1,1,1,1,0,0, 8'd0, 8'h11, 8'h00)};
        tbl[15] = '{1, 8'h11, 0, 8'h00, mk(1,1,1,1,0,0, 8'd0, 8'h11, 8'h00)};
        tbl[16] = '{1, 8'h11, 0, 8'h00, mk(1,0,1,1,0,0, 8'd0, 8'h11, 8'h00)};
        tbl[17] = '{1, 8'h11, 0, 8'h00, mk(1,0,0,0,0,1, 8'd1, 8'h11, 8'h00)};
        tbl[18] = '{1, 8'h11, 0, 8'h00, mk(1,0,0,0,0,0, 8'd1, 8'h11, 8'h00)};

        bus.valid_par_0 = 1'b0;
        bus.data_par_0  = 8'h00;
        bus.valid_par_1 = 1'b0;
        bus.data_par_1  = 8'h00;
        repeat (2) @(posedge clk_f);
        #1;
        chk("reset_outputs", 32'(obs()), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            sbq.push_back(tbl[i].exp);
            step(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            e = sbq.pop_front();
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(e));
        end
        losses = 1;

        // Repeated lane-1 loss/retrain cycles drive the loss counter into saturation
        for (int n = 0; n < 255; n++) begin
            repeat (4) step(1, 8'h11, 1, 8'hBC);
            step(1, 8'h00, 1, 8'h00);
            step(1, 8'h7C, 1, 8'h7C);
            chk("retrain_active", 32'(bus.link_active), 32'd1);
            repeat (4) step(1, 8'h11, 0, 8'h00);
            step(1, 8'h11, 0, 8'h00);
            losses++;
            chk("loss_flush", 32'(bus.flush), 32'd1);
            chk("loss_cnt", 32'(bus.sync_loss_cnt), 32'(losses > 255 ? 255 : losses));
        end
        step(1, 8'h11, 0, 8'h00);
        chk("flush_single", 32'(bus.flush), 32'd0);

        repeat (4) step(1, 8'h11, 1, 8'hBC);
        step(1, 8'h00, 1, 8'h00);
        step(1, 8'h7C, 1, 8'h7C);
        chk("pre_reset_active", 32'(bus.link_active), 32'd1);
        #2 reset = 1'b1;
        #1 chk("async_reset_now", 32'(obs()), 32'd0);
        @(posedge clk_f);
        #1 chk("async_reset_hold", 32'(obs()), 32'd0);
        reset = 1'b0;

        step(1, 8'hBC, 0, 8'h00);
        step(1, 8'hBC, 0, 8'h00);
        step(1, 8'hBC, 0, 8'h00);
        step(1, 8'h55, 0, 8'h00);
        step(1, 8'hBC, 0, 8'h00);
        chk("restart_no_sync", 32'(bus.lane_sync_0), 32'd0);
        step(1, 8'hBC, 0, 8'h00);
        step(1, 8'hBC, 0, 8'h00);
        chk("restart_cnt3", 32'(bus.lane_sync_0), 32'd0);
        step(1, 8'hBC, 0, 8'h00);
        chk("restart_sync", 32'(bus.lane_sync_0), 32'd1);

        repeat (3) step(1, 8'h00, 1, 8'hBC);
        chk("lane1_not_yet", 32'(bus.lane_sync_1), 32'd0);
        step(1, 8'h00, 1, 8'hBC);
        chk("lane1_sync", 32'(bus.lane_sync_1), 32'd1);
        step(1, 8'h7C, 1, 8'h7C);
        chk("train_not_active", 32'(bus.link_active), 32'd0);
        step(1, 8'h7C, 1, 8'h7C);
        chk("final_active", 32'(bus.link_active), 32'd1);
        chk("final_cnt", 32'(bus.sync_loss_cnt), 32'd0);
        step(1, 8'h42, 1, 8'h43);
        chk("final_fwd", 32'({bus.valid_fwd_0, bus.valid_fwd_1, bus.data_fwd_0, bus.data_fwd_1}),
            32'({2'b11, 8'h42, 8'h43}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
